algorithm_sequencer: RTL and testbench

//  Operator-facing controller for the scaling coprocessor. It debounces two push-buttons
//  and cycles the selected algorithm: NN=0, PR=1, DC=2, BA=3.
//  It launches the coprocessor with a one-cycle START pulse and holds the selection frozen

---
 rtl/algorithm_sequencer.sv | 131 +++++++++++++
 tb/tb_algorithm_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/algorithm_sequencer.sv
// rtl/algorithm_sequencer.sv - debounced two-key algorithm selector and coprocessor launcher
// Cycles NN/PR/DC/BA on NEXT and launches a run on START, keeping the selection frozen until COP_DONE.
module algorithm_sequencer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       KEY_NEXT_N,
  input  logic       KEY_START_N,
  input  logic       COP_READY,
  input  logic       COP_DONE,
  output logic [1:0] ALGORITHM,
  output logic       COP_START,
  output logic       BUSY,
  output logic [1:0] STATE
);

  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  // Key index 0 is NEXT, index 1 is START; both share one conditioning path.
  logic [1:0]       w_key_raw;
  logic [1:0]       r_sync1;
  logic [1:0]       r_sync2;
  logic [1:0]       r_stable;
  logic [1:0]       r_stable_d;
  logic [1:0]       r_press;
  logic [CNT_W-1:0] r_cnt [2];

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_alg;
  logic [1:0] w_alg_nxt;
  logic       r_start;
  logic       w_start_nxt;
  logic       r_busy;
  logic       w_next_pulse;
  logic       w_start_pulse;

  assign w_key_raw     = {KEY_START_N, KEY_NEXT_N};
  assign w_next_pulse  = r_press[0];
  assign w_start_pulse = r_press[1];

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_sync1    <= 2'b11;
      r_sync2    <= 2'b11;
      r_stable   <= 2'b11;
      r_stable_d <= 2'b11;
      r_press    <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1    <= w_key_raw;
      r_sync2    <= r_sync1;
      r_stable_d <= r_stable;
      // Only the stable 1->0 edge produces an event; releases are ignored.
      r_press    <= r_stable_d & ~r_stable;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == LP_CNT_LAST) begin
          r_stable[i] <= r_sync2[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_alg_nxt   = r_alg;
    w_start_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_pulse) begin
          if (COP_READY) begin
            w_start_nxt = 1'b1;
            w_state_nxt = S_RUN;
          end else begin
            w_state_nxt = S_WAIT;
          end
        end else if (w_next_pulse) begin
          w_alg_nxt = r_alg + 2'd1;
        end
      end
      S_WAIT: begin
        if (COP_READY) begin
          w_start_nxt = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        // A DONE coincident with our own START belongs to no run of ours.
        if (COP_DONE && !r_start) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= S_IDLE;
      r_alg   <= 2'd0;
      r_start <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_alg   <= w_alg_nxt;
      r_start <= w_start_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

  assign ALGORITHM = r_alg;
  assign COP_START = r_start;
  assign BUSY      = r_busy;
  assign STATE     = r_state;

endmodule

// File: tb/tb_algorithm_sequencer.sv
// tb/tb_algorithm_sequencer.sv - scoreboard bench for algorithm_sequencer
// Stimulus predicts selection steps and launches into a queue; a negedge monitor pops and compares.
module tb_algorithm_sequencer;

  localparam int D   = 4;
  localparam int LAT = D + 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_next_n;
  logic       key_start_n;
  logic       cop_ready;
  logic       cop_done;
  logic [1:0] alg;
  logic       cop_start;
  logic       busy;
  logic [1:0] state;

  always #5 clk = ~clk;

  algorithm_sequencer #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .CLOCK_50    (clk),
    .RESET_N     (rst_n),
    .KEY_NEXT_N  (key_next_n),
    .KEY_START_N (key_start_n),
    .COP_READY   (cop_ready),
    .COP_DONE    (cop_done),
    .ALGORITHM   (alg),
    .COP_START   (cop_start),
    .BUSY        (busy),
    .STATE       (state)
  );

  typedef struct {
    int kind;
    int val;
    int cyc;
  } ev_t;

  ev_t exp_q[$];
  ev_t ev;
  int  n_tests    = 0;
  int  n_fail     = 0;
  int  cyc        = 0;
  int  m_alg      = 0;
  int  prev_alg   = 0;
  int  ev_kind    = 0;
  bit  prev_start = 1'b0;

  task automatic chk(input string name, input int act, input int exp_v);
    n_tests++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp_v, cyc);
    end
  endtask

  always @(posedge clk) cyc = cyc + 1;

  // Observed events: a change of ALGORITHM (kind 0) or a COP_START pulse (kind 1).
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_alg   = 0;
      prev_start = 1'b0;
    end else begin
      if (int'(alg) != prev_alg || cop_start) begin
        ev_kind = cop_start ? 1 : 0;
        if (exp_q.size() == 0) begin
          chk("unexpected_event_kind", ev_kind, -1);
        end else begin
          ev = exp_q.pop_front();
          chk("ev_kind", ev_kind, ev.kind);
          chk("ev_alg", int'(alg), ev.val);
          chk("ev_cycle", cyc, ev.cyc);
        end
      end
      if (cop_start && prev_start) chk("start_two_cycles", 1, 0);
      prev_alg   = int'(alg);
      prev_start = cop_start;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic press_next(input int hold, input bit expect_step);
    int t;
    @(negedge clk);
    t = cyc;
    key_next_n = 1'b0;
    if (expect_step) begin
      m_alg = (m_alg + 1) % 4;
      exp_q.push_back('{0, m_alg, t + LAT});
    end
    wait_cyc(hold);
    key_next_n = 1'b1;
    wait_cyc(D + 6);
  endtask

  task automatic glitch(input int len);
    @(negedge clk);
    key_next_n = 1'b0;
    wait_cyc(len);
    key_next_n = 1'b1;
    wait_cyc(D + 4);
  endtask

  task automatic do_run(input bit rdy, input int rdelay, input bit early_done, input int n_next);
    int t;
    int ts;
    @(negedge clk);
    t = cyc;
    cop_ready = rdy;
    key_start_n = 1'b0;
    ts = rdy ? t + LAT : t + LAT + rdelay + 1;
    exp_q.push_back('{1, m_alg, ts});
    wait_cyc(6);
    key_start_n = 1'b1;
    if (!rdy) begin
      wait_until(t + LAT);
      chk("wait_state", int'(state), 1);
      chk("wait_busy", int'(busy), 1);
      chk("wait_no_start", int'(cop_start), 0);
      wait_until(t + LAT + rdelay);
      cop_ready = 1'b1;
    end
    wait_until(ts);
    chk("run_start", int'(cop_start), 1);
    chk("run_state", int'(state), 2);
    chk("run_busy", int'(busy), 1);
    if (early_done) cop_done = 1'b1;
    @(negedge clk);
    cop_done = 1'b0;
    chk("start_one_cycle", int'(cop_start), 0);
    chk("early_done_ignored", int'(state), 2);
    for (int i = 0; i < n_next; i++) press_next(7, 1'b0);
    chk("run_hold_alg", int'(alg), m_alg);
    cop_done = 1'b1;
    @(negedge clk);
    cop_done = 1'b0;
    chk("done_idle", int'(state), 0);
    chk("done_busy", int'(busy), 0);
    cop_ready = 1'($urandom_range(0, 1));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst_n       = 1'b0;
    key_next_n  = 1'b1;
    key_start_n = 1'b1;
    cop_ready   = 1'b0;
    cop_done    = 1'b0;
    wait_cyc(3);
    chk("in_reset", int'({alg, cop_start, busy, state}), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("reset_idle", int'({alg, cop_start, busy, state}), 0);
    end

    for (int i = 0; i < 4; i++) press_next(10, 1'b1);
    chk("wrap_to_nn", int'(alg), 0);

    for (int i = 0; i < 5; i++) glitch(3);
    chk("glitch_alg", int'(alg), m_alg);

    press_next(10, 1'b1);
    press_next(10, 1'b1);
    do_run(1'b1, 0, 1'b0, 2);
    do_run(1'b0, 7, 1'b0, 1);
    do_run(1'b1, 0, 1'b1, 0);

    @(negedge clk);
    cop_done = 1'b1;
    @(negedge clk);
    cop_done = 1'b0;
    chk("idle_done_ignored", int'(state), 0);

    @(negedge clk);
    t = cyc;
    cop_ready   = 1'b1;
    key_next_n  = 1'b0;
    key_start_n = 1'b0;
    exp_q.push_back('{1, m_alg, t + LAT});
    wait_cyc(7);
    key_next_n  = 1'b1;
    key_start_n = 1'b1;
    wait_until(t + LAT + 1);
    chk("both_keys_run", int'(state), 2);
    cop_done = 1'b1;
    @(negedge clk);
    cop_done = 1'b0;
    wait_cyc(D + 4);
    chk("both_keys_alg", int'(alg), m_alg);

    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(0, 2))
        0:       press_next(int'($urandom_range(6, 12)), 1'b1);
        1:       glitch(int'($urandom_range(1, 3)));
        default: do_run(1'($urandom_range(0, 1)), int'($urandom_range(1, 8)),
                        1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
      endcase
    end

    while (m_alg != 3) press_next(8, 1'b1);
    @(negedge clk);
    t = cyc;
    cop_ready = 1'b1;
    key_start_n = 1'b0;
    exp_q.push_back('{1, m_alg, t + LAT});
    wait_cyc(6);
    key_start_n = 1'b1;
    wait_until(t + LAT + 2);
    chk("pre_reset_run", int'(state), 2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_alg", int'(alg), 0);
    chk("async_reset_start", int'(cop_start), 0);
    chk("async_reset_busy", int'(busy), 0);
    chk("async_reset_state", int'(state), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    m_alg = 0;
    wait_cyc(15);
    chk("post_reset_state", int'(state), 0);
    chk("post_reset_alg", int'(alg), 0);

    wait_cyc(2);
    chk("events_left", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
